// File: rtl/frame_seq_pkg.sv
// Shared state encoding and default buffer geometry for the frame sequencer
// and the memory models that sit around it.
package frame_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    LAUNCH    = 3'd2,
    WAIT_BUSY = 3'd3,
    RENDER    = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam int unsigned FB_DEPTH_DEF       = 76800;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 25_000_000;
  localparam logic [11:0] CLEAR_PIXEL_DEF    = 12'h000;
  localparam logic [7:0]  CLEAR_Z_DEF        = 8'hFF;

endpackage

// File: rtl/frame_sequencer_if.sv
// One buffer write port (address, write enable, data); used for both the
// frame buffer and the Z-buffer, on the rasterizer side and the memory side.
interface frame_sequencer_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
);

  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] data;

  modport master (output addr, we, data);
  modport slave  (input  addr, we, data);

endinterface

// File: rtl/fb_clear_engine.sv
// Buffer clear address generator: after a start pulse it walks 0..DEPTH-1,
// one address per cycle, and flags the final address.
module fb_clear_engine
  import frame_seq_pkg::*;
#(
  parameter int unsigned DEPTH  = FB_DEPTH_DEF,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] addr,
  output logic              we,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q;
  logic              run_q;

  assign addr = addr_q;
  assign we   = run_q;
  assign last = run_q && (addr_q == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      run_q  <= 1'b0;
    end else if (start) begin
      addr_q <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      if (last) begin
        addr_q <= '0;
        run_q  <= 1'b0;
      end else begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame controller: clears FB/ZB, launches geometry, waits for the
// rasterizer under a watchdog, and owns the shared buffer write ports.
//
// state     | meaning
// IDLE      | waiting for a start edge; frame index may advance
// CLEAR     | clear engine writes CLEAR_PIXEL / CLEAR_Z to every address
// LAUNCH    | one-cycle geometry start pulse
// WAIT_BUSY | waiting for the rasterizer to report busy
// RENDER    | waiting for the rasterizer to go idle
// DONE      | one-cycle completion pulse (with timeout flag on expiry)
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int unsigned      FB_DEPTH       = FB_DEPTH_DEF,
  parameter int unsigned      ADDR_W         = 17,
  parameter int unsigned      PIX_W          = 12,
  parameter int unsigned      Z_W            = 8,
  parameter logic [PIX_W-1:0] CLEAR_PIXEL    = CLEAR_PIXEL_DEF,
  parameter logic [Z_W-1:0]   CLEAR_Z        = CLEAR_Z_DEF,
  parameter int unsigned      FRAME_W        = 4,
  parameter int unsigned      TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_increment_frame,
  input  logic               i_rast_busy,
  frame_sequencer_if.slave   r_fb,
  frame_sequencer_if.slave   r_zb,
  frame_sequencer_if.master  fb,
  frame_sequencer_if.master  zb_w,
  output logic               o_geom_start,
  output logic [FRAME_W-1:0] o_frame_idx,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_timeout
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

  state_t             state_q, state_d;
  logic               start_q, inc_q;
  logic               start_edge, inc_edge;
  logic [WD_W-1:0]    wd_q;
  logic               wd_expire, in_watch;
  logic               timeout_q;
  logic [FRAME_W-1:0] frame_idx_q;
  logic               clr_start, clr_we, clr_last;
  logic [ADDR_W-1:0]  clr_addr;

  assign start_edge = i_start & ~start_q;
  assign inc_edge   = i_increment_frame & ~inc_q;
  assign in_watch   = (state_q == WAIT_BUSY) || (state_q == RENDER);
  // The counter is about to reach TIMEOUT_CYCLES-1 on this edge.
  assign wd_expire  = (wd_q == WD_W'(TIMEOUT_CYCLES - 2));
  assign clr_start  = (state_q == IDLE) && start_edge;

  fb_clear_engine #(
    .DEPTH  (FB_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .start (clr_start),
    .addr  (clr_addr),
    .we    (clr_we),
    .last  (clr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      inc_q       <= 1'b0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
      frame_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= i_start;
      inc_q     <= i_increment_frame;
      timeout_q <= in_watch && wd_expire;
      if (in_watch) begin
        wd_q <= wd_q + WD_W'(1);
      end else begin
        wd_q <= '0;
      end
      if ((state_q == IDLE) && inc_edge) begin
        frame_idx_q <= frame_idx_q + FRAME_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_edge) state_d = CLEAR;
      CLEAR:     if (clr_last) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (wd_expire) state_d = DONE;
        else if (i_rast_busy) state_d = RENDER;
      end
      RENDER:    if (wd_expire || !i_rast_busy) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign o_busy       = (state_q != IDLE);
  assign o_geom_start = (state_q == LAUNCH);
  assign o_frame_done = (state_q == DONE);
  assign o_timeout    = (state_q == DONE) && timeout_q;
  assign o_frame_idx  = frame_idx_q;

  // Rasterizer writes are dropped while clearing; otherwise zero-latency pass-through.
  always_comb begin
    if (state_q == CLEAR) begin
      fb.addr   = clr_addr;
      fb.we     = clr_we;
      fb.data   = CLEAR_PIXEL;
      zb_w.addr = clr_addr;
      zb_w.we   = clr_we;
      zb_w.data = CLEAR_Z;
    end else begin
      fb.addr   = r_fb.addr;
      fb.we     = r_fb.we;
      fb.data   = r_fb.data;
      zb_w.addr = r_zb.addr;
      zb_w.we   = r_zb.we;
      zb_w.data = r_zb.data;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: idle vectors, directed frame sequences and a
// randomized run checked against a cycle-offset timeline model.
module tb_frame_sequencer;

  localparam int DEPTH = 16;
  localparam int TMO   = 64;
  localparam logic [11:0] CLR_PIX = 12'h000;
  localparam logic [7:0]  CLR_Z   = 8'hFF;

  typedef struct {
    logic        inc;
    logic [16:0] fa;
    logic        fw;
    logic [11:0] fp;
    logic [16:0] za;
    logic        zw;
    logic [7:0]  zd;
    logic [3:0]  exp_idx;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_start = 1'b0, i_increment_frame = 1'b0, i_rast_busy = 1'b0;
  logic       o_geom_start, o_busy, o_frame_done, o_timeout;
  logic [3:0] o_frame_idx;
  int         checks = 0;
  int         errors = 0;

  frame_sequencer_if #(.ADDR_W(17), .DATA_W(12)) r_fb ();
  frame_sequencer_if #(.ADDR_W(17), .DATA_W(8))  r_zb ();
  frame_sequencer_if #(.ADDR_W(17), .DATA_W(12)) fb ();
  frame_sequencer_if #(.ADDR_W(17), .DATA_W(8))  zb_w ();

  frame_sequencer #(
    .FB_DEPTH       (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_start           (i_start),
    .i_increment_frame (i_increment_frame),
    .i_rast_busy       (i_rast_busy),
    .r_fb              (r_fb),
    .r_zb              (r_zb),
    .fb                (fb),
    .zb_w              (zb_w),
    .o_geom_start      (o_geom_start),
    .o_frame_idx       (o_frame_idx),
    .o_busy            (o_busy),
    .o_frame_done      (o_frame_done),
    .o_timeout         (o_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rast(input logic [16:0] fa, input logic fw, input logic [11:0] fp,
                          input logic [16:0] za, input logic zw, input logic [7:0] zd);
    r_fb.addr = fa; r_fb.we = fw; r_fb.data = fp;
    r_zb.addr = za; r_zb.we = zw; r_zb.data = zd;
  endtask

  task automatic chk_ports(input string tag, input logic [16:0] fa, input logic fw, input logic [11:0] fp,
                           input logic [16:0] za, input logic zw, input logic [7:0] zd);
    chk({tag, ".fb_addr"}, 32'(fb.addr), 32'(fa));
    chk({tag, ".fb_we"},   32'(fb.we),   32'(fw));
    chk({tag, ".fb_pix"},  32'(fb.data), 32'(fp));
    chk({tag, ".zb_addr"}, 32'(zb_w.addr), 32'(za));
    chk({tag, ".zb_we"},   32'(zb_w.we),   32'(zw));
    chk({tag, ".zb_data"}, 32'(zb_w.data), 32'(zd));
  endtask

  task automatic chk_ctrl(input string tag, input logic busy, input logic geom,
                          input logic done, input logic to);
    chk({tag, ".busy"},    32'(o_busy),       32'(busy));
    chk({tag, ".geom"},    32'(o_geom_start), 32'(geom));
    chk({tag, ".done"},    32'(o_frame_done), 32'(done));
    chk({tag, ".timeout"}, 32'(o_timeout),    32'(to));
  endtask

  task automatic do_reset();
    i_start = 1'b0; i_increment_frame = 1'b0; i_rast_busy = 1'b0;
    set_rast('0, 1'b0, '0, '0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk_ctrl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.idx", 32'(o_frame_idx), 32'd0);
    chk_ports("reset", '0, 1'b0, '0, '0, 1'b0, '0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Ticks until o_frame_done or the bound; returns ticks taken.
  task automatic wait_done(input string tag, input int max_cyc, output int n);
    n = 0;
    while (o_frame_done !== 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    chk({tag, ".done_seen"}, 32'(o_frame_done), 32'd1);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic chk_clear_run(input string tag);
    for (int k = 0; k < DEPTH; k++) begin
      chk_ports(tag, 17'(k), 1'b1, CLR_PIX, 17'(k), 1'b1, CLR_Z);
      chk({tag, ".busy"}, 32'(o_busy), 32'd1);
      chk({tag, ".geom"}, 32'(o_geom_start), 32'd0);
      tick();
    end
    chk({tag, ".launch"}, 32'(o_geom_start), 32'd1);
  endtask

  initial begin
    vec_t        vec [6];
    int          n;
    logic [11:0] pix;
    logic [7:0]  zd;
    // random-run model
    bit          in_frame, m_to, idle, prev_start, prev_inc;
    bit          s_start, s_inc, s_busy, e_clear, e_busy, e_geom, e_done;
    int          t0, d, b, done_off, off, m_idx, frames;
    logic [16:0] rfa, rza;
    logic        rfw, rzw;
    logic [11:0] rfp;
    logic [7:0]  rzd;

    vec[0] = '{1'b1, 17'h00005, 1'b1, 12'hABC, 17'h00005, 1'b1, 8'h12, 4'd1};
    vec[1] = '{1'b0, 17'h1FFFF, 1'b0, 12'hFFF, 17'h12C00, 1'b1, 8'h00, 4'd1};
    vec[2] = '{1'b1, 17'h12BFF, 1'b1, 12'h0F0, 17'h00000, 1'b0, 8'h7F, 4'd2};
    vec[3] = '{1'b1, 17'h00001, 1'b0, 12'h000, 17'h1FFFF, 1'b1, 8'hFF, 4'd2};
    vec[4] = '{1'b0, 17'h0AAAA, 1'b1, 12'h555, 17'h15555, 1'b0, 8'hA5, 4'd2};
    vec[5] = '{1'b1, 17'h00010, 1'b1, 12'h321, 17'h00020, 1'b1, 8'h5A, 4'd3};

    do_reset();

    // Idle vectors: pass-through and increment edge detection.
    for (int i = 0; i < 6; i++) begin
      i_increment_frame = vec[i].inc;
      set_rast(vec[i].fa, vec[i].fw, vec[i].fp, vec[i].za, vec[i].zw, vec[i].zd);
      #1;
      chk_ports("idle_vec", vec[i].fa, vec[i].fw, vec[i].fp, vec[i].za, vec[i].zw, vec[i].zd);
      chk_ctrl("idle_vec", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("idle_vec.idx", 32'(o_frame_idx), 32'(vec[i].exp_idx));
    end
    i_increment_frame = 1'b0;
    tick();

    // Full frame: clear over live rasterizer writes, 10 busy cycles, start held high.
    set_rast(17'd3, 1'b1, 12'h5A5, 17'd3, 1'b1, 8'h11);
    i_start = 1'b1;
    tick();
    chk_clear_run("frame_a.clear");
    chk_ports("frame_a.launch", 17'd3, 1'b1, 12'h5A5, 17'd3, 1'b1, 8'h11);
    tick();
    i_rast_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) i_increment_frame = 1'b1;
      if (i == 5) i_increment_frame = 1'b0;
      pix = 12'($urandom);
      zd  = 8'($urandom);
      set_rast(17'd5, 1'b1, pix, 17'd5, 1'b1, zd);
      #1;
      chk_ports("frame_a.render", 17'd5, 1'b1, pix, 17'd5, 1'b1, zd);
      chk_ctrl("frame_a.render", 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    i_rast_busy = 1'b0;
    #1;
    chk("frame_a.pre_done", 32'(o_frame_done), 32'd0);
    tick();
    chk_ctrl("frame_a.done", 1'b1, 1'b0, 1'b1, 1'b0);
    chk("frame_a.idx_kept", 32'(o_frame_idx), 32'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_ctrl("frame_a.start_held", 1'b0, 1'b0, 1'b0, 1'b0);
    end
    i_start = 1'b0;
    set_rast('0, 1'b0, '0, '0, 1'b0, '0);
    tick();

    // Watchdog: rasterizer never reports busy.
    pulse_start();
    chk_clear_run("frame_b.clear");
    wait_done("frame_b", 200, n);
    chk("frame_b.done_latency", 32'(n), 32'(TMO));
    chk("frame_b.timeout", 32'(o_timeout), 32'd1);
    tick();
    chk_ctrl("frame_b.idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // 17 increment edges from reset wrap to 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      i_increment_frame = 1'b1;
      tick();
      i_increment_frame = 1'b0;
      tick();
    end
    chk("wrap.idx", 32'(o_frame_idx), 32'd1);

    // Reset at clear address 7, then a complete re-clear.
    pulse_start();
    for (int i = 0; i < 7; i++) tick();
    chk("midreset.addr7", 32'(fb.addr), 32'd7);
    rst_n = 1'b0;
    #1;
    chk_ctrl("midreset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midreset.idx", 32'(o_frame_idx), 32'd0);
    chk_ports("midreset", '0, 1'b0, '0, '0, 1'b0, '0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("midreset.idle", 32'(o_busy), 32'd0);
    pulse_start();
    chk_clear_run("midreset.reclear");
    wait_done("midreset", 200, n);
    tick();

    // Randomized run against the timeline model (offsets from the start-edge cycle).
    do_reset();
    in_frame = 1'b0; m_to = 1'b0; prev_start = 1'b0; prev_inc = 1'b0;
    t0 = 0; d = 0; b = 0; done_off = 0; m_idx = 0; frames = 0;
    for (int c = 0; c < 3000; c++) begin
      off = c - t0;
      if (in_frame && off > done_off) in_frame = 1'b0;
      idle    = !in_frame;
      e_busy  = in_frame;
      e_clear = in_frame && off >= 1 && off <= DEPTH;
      e_geom  = in_frame && off == DEPTH + 1;
      e_done  = in_frame && off == done_off;

      s_start = idle ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      s_inc   = ($urandom_range(0, 1) == 1);
      s_busy  = in_frame && off >= DEPTH + 2 + d && off < DEPTH + 2 + d + b;
      rfa = 17'($urandom); rfw = 1'($urandom); rfp = 12'($urandom);
      rza = 17'($urandom); rzw = 1'($urandom); rzd = 8'($urandom);
      i_start = s_start; i_increment_frame = s_inc; i_rast_busy = s_busy;
      set_rast(rfa, rfw, rfp, rza, rzw, rzd);
      #1;
      chk_ctrl("rnd", e_busy, e_geom, e_done, e_done && m_to);
      chk("rnd.idx", 32'(o_frame_idx), 32'(m_idx));
      if (e_clear)
        chk_ports("rnd.clear", 17'(off - 1), 1'b1, CLR_PIX, 17'(off - 1), 1'b1, CLR_Z);
      else
        chk_ports("rnd.pass", rfa, rfw, rfp, rza, rzw, rzd);

      if (idle) begin
        if (s_inc && !prev_inc) m_idx = (m_idx + 1) % 16;
        if (s_start && !prev_start) begin
          in_frame = 1'b1;
          t0 = c;
          frames++;
          case ($urandom_range(0, 3))
            0:       begin d = $urandom_range(0, 80); b = 0; end
            1:       begin d = $urandom_range(0, 20); b = $urandom_range(1, 30); end
            2:       begin d = $urandom_range(0, 10); b = $urandom_range(64, 80); end
            default: begin d = $urandom_range(0, 3);  b = $urandom_range(1, 3); end
          endcase
          // Busy falling by WAIT offset TMO-2 completes normally; otherwise the watchdog fires.
          if (b > 0 && d + b <= TMO - 3) begin
            done_off = DEPTH + 1 + d + b + 2;
            m_to = 1'b0;
          end else begin
            done_off = DEPTH + 1 + TMO;
            m_to = 1'b1;
          end
        end
      end
      prev_start = s_start;
      prev_inc   = s_inc;
      tick();
    end
    chk("rnd.frames_started", 32'(frames > 5), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
